// File: rtl/imem_responder.sv
// Instruction-memory responder: a word array behind a fixed-latency fetch handshake,
// with a side preload port so a bench or boot loader can fill the array.
`ifndef XLEN
`define XLEN 32
`endif

module imem_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_DataReq,
    input  logic [`XLEN-1:0]  i_Addr,
    output logic [`XLEN-1:0]  o_Data,
    output logic              o_MemReady,
    output logic              o_Err,
    input  logic              i_PreWen,
    input  logic [`XLEN-1:0]  i_PreAddr,
    input  logic [`XLEN-1:0]  i_PreData
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [`XLEN-1:0]   addr_q, addr_d;
    logic [`XLEN-1:0]   data_q, data_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;

    logic [31:0]        mem [DEPTH];

    logic [`XLEN-1:0]   rd_addr;
    logic               rd_fault;
    logic [AW-1:0]      rd_idx;
    logic               pre_fault;
    logic [AW-1:0]      pre_idx;

    function automatic logic addr_fault(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ((off >> 2) >= 32'(DEPTH));
    endfunction

    function automatic logic [AW-1:0] addr_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return AW'(off >> 2);
    endfunction

    // With LATENCY=1 the RESP load happens on the accepting edge, so the live address is used.
    always_comb begin
        rd_addr   = (state_q == IDLE) ? i_Addr : addr_q;
        rd_fault  = addr_fault(rd_addr);
        rd_idx    = addr_index(rd_addr);
        pre_fault = addr_fault(i_PreAddr);
        pre_idx   = addr_index(i_PreAddr);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_DataReq) begin
                    addr_d = i_Addr;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        data_d  = rd_fault ? 32'd0 : mem[rd_idx];
                        err_d   = rd_fault;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!i_DataReq) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    data_d  = rd_fault ? 32'd0 : mem[rd_idx];
                    err_d   = rd_fault;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Ready is registered out of RESP, which puts the pulse LATENCY edges after acceptance.
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    // Array has no reset so its contents survive i_rst.
    always_ff @(posedge i_clk) begin
        if (i_PreWen && !pre_fault) begin
            mem[pre_idx] <= i_PreData;
        end
    end

    assign o_Data     = data_q;
    assign o_Err      = err_q;
    assign o_MemReady = ready_q;

endmodule
